seg_pattern_qualifier: RTL
==========================

// Module: seg_pattern_qualifier
// PURPOSE
//  Programmable, debounced multi-pattern detector for the adder/7-segment display path.
//  Compares a registered WIDTH-bit sample of display/operand state against NPAT
//  loadable pattern/mask entries. Asserts a sticky 'set' flag once the same entry
//  has matched for HOLD consecutive valid samples, and reports that entry's index.
//  Replaces fixed hard-wired sum-of-products match decoders.
// PARAMETERS
//  WIDTH  19  bits per sample, pattern and mask
//  NPAT   2   number of pattern entries (>=1)
//  HOLD   4   consecutive matching valid samples required before set (>=1)
// PORTS
//  clk        in   1                 system clock, rising edge
//  rst_n      in   1                 asynchronous reset, active low
//  in_vec     in   WIDTH             sample; bit WIDTH-1 = Op, then A..P, r, s down to bit 0
//  in_valid   in   1                 in_vec is valid this cycle
//  load_en    in   1                 write one table entry this cycle
//  load_idx   in   $clog2(NPAT)|1    entry to write; out-of-range index ignored
//  load_pat   in   WIDTH             pattern value
//  load_mask  in   WIDTH             1 = bit compared, 0 = don't care
//  load_ena   in   1                 entry enable written with pattern
//  clear      in   1                 drop set, return to IDLE
//  set        out  1                 sticky qualified-match flag
//  match_idx  out  $clog2(NPAT)|1    entry that qualified; valid while set=1
//  busy       out  1                 1 while in QUAL
// BEHAVIOUR
//  Reset: all entries disabled, pattern=0, mask=all-ones; sample reg=0; v_q=0; cnt=0;
//   state=IDLE; set=0, match_idx=0, busy=0.
//  Stage 1: on in_valid, capture in_vec->s_q; v_q <= in_valid every cycle.
//  Compare: hit[i] = ena[i] & ((s_q ^ pat[i]) & mask[i]) == 0; lowest-index hit wins (cur_idx).
//  FSM, evaluated only when v_q=1; v_q=0 holds state and cnt unchanged:
//   IDLE: hit -> if HOLD==1 go SET, else go QUAL with cnt=1, cand=cur_idx; no hit -> stay.
//   QUAL: hit & cur_idx==cand -> cnt+1; SET when cnt+1==HOLD.
//         hit & cur_idx!=cand -> restart: cnt=1, cand=cur_idx.
//         no hit -> IDLE, cnt=0.
//   SET: set=1, match_idx=cand; hold regardless of input until clear.
//  Latency: HOLD matching samples captured at edges k..k+HOLD-1 -> set=1 after edge k+HOLD.
//  clear (any state): next state IDLE, cnt=0, set=0. clear has priority over a same-cycle qualify.
//  Load: the entry is updated at the edge; the compare uses the new entry from the next cycle.
//   A load to cand while in QUAL forces a restart to IDLE, cnt=0. A load during SET does not affect set.
//  Simultaneous load_en and clear: both take effect.
//  cnt width $clog2(HOLD+1); saturates, never wraps.
//  Reset asserted mid-operation: everything returns to reset values asynchronously.
//   The table is lost and must be reloaded.
// STRUCTURE
//  Package seg_match_pkg: state enum {IDLE, QUAL, SET}; IDXW/CNTW localparam helpers;
//   default-pattern constants PAT_SUM_A=19'h30D40 and PAT_ALL1=19'h3FFFF,
//   with MASK_FULL=19'h7FFFF.
//  Sub-module seg_pattern_cmp_bank: combinational NPAT compare + priority encoder
//   (outputs hit_any, cur_idx). Table regs, sample reg, FSM and counter live in the top.
// TESTING
//  Load e0=(19'h30D40, full mask, en), e1=(19'h3FFFF, full mask, en); drive 19'h30D40
//   with in_valid for 4 cycles -> set rises 4 edges after the first capture, match_idx=0, busy low.
//  Drive 19'h3FFFF 3 cycles, then 19'h00001 once -> set stays 0, back to IDLE.
//   Then 19'h3FFFF x4 -> set=1, match_idx=1.
//  Alternate 19'h30D40 / 19'h3FFFF every cycle for 10 cycles -> repeated restarts, set never asserts.
//  Matching stream with in_valid gapped (1,0,0,1,1,0,1) -> set after the 4th valid sample;
//   the gaps do not reset cnt.
//  In SET, pulse clear in the same cycle a new qualifying sample completes -> set=0,
//   state IDLE, cnt=0.
//  Mask e0 to 19'h40000 with pattern 0 -> any sample with Op=0 qualifies;
//   assert rst_n low mid-QUAL -> set=0 and entries disabled immediately.

Source files
------------

// File: rtl/seg_match_pkg.sv
// Shared types, width helpers and default pattern constants for the
// segment-display pattern qualifier.
package seg_match_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        QUAL = 2'd1,
        SET  = 2'd2
    } state_t;

    localparam logic [18:0] PAT_SUM_A = 19'h30D40;
    localparam logic [18:0] PAT_ALL1  = 19'h3FFFF;
    localparam logic [18:0] MASK_FULL = 19'h7FFFF;

    // Entry index width, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_w(input int hold);
        return $clog2(hold + 1);
    endfunction

endpackage

// File: rtl/seg_pattern_cmp_bank.sv
// Masked compare of one sample against every table entry, followed by a
// lowest-index-wins priority encoder.
module seg_pattern_cmp_bank
    import seg_match_pkg::*;
#(
    parameter int WIDTH = 19,
    parameter int NPAT  = 2
) (
    input  logic [WIDTH-1:0]            sample,
    input  logic [NPAT-1:0][WIDTH-1:0]  pat,
    input  logic [NPAT-1:0][WIDTH-1:0]  mask,
    input  logic [NPAT-1:0]             ena,
    output logic                        hit_any,
    output logic [idx_w(NPAT)-1:0]      cur_idx
);

    localparam int IDXW = idx_w(NPAT);

    logic [NPAT-1:0] hit_s;

    // Per-entry hit and priority select; scanning downward leaves the lowest hit.
    always_comb begin
        hit_s   = {NPAT{1'b0}};
        cur_idx = {IDXW{1'b0}};
        for (int i = 0; i < NPAT; i++) begin
            hit_s[i] = ena[i] & (((sample ^ pat[i]) & mask[i]) == {WIDTH{1'b0}});
        end
        for (int i = NPAT - 1; i >= 0; i--) begin
            cur_idx = hit_s[i] ? IDXW'(i) : cur_idx;
        end
        hit_any = |hit_s;
    end

endmodule

// File: rtl/seg_pattern_qualifier.sv
// Debounced multi-pattern detector: a sample must match the same table entry
// for HOLD consecutive valid samples before the sticky set flag rises.
module seg_pattern_qualifier
    import seg_match_pkg::*;
#(
    parameter int WIDTH = 19,
    parameter int NPAT  = 2,
    parameter int HOLD  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [WIDTH-1:0]        in_vec,
    input  logic                    in_valid,
    input  logic                    load_en,
    input  logic [idx_w(NPAT)-1:0]  load_idx,
    input  logic [WIDTH-1:0]        load_pat,
    input  logic [WIDTH-1:0]        load_mask,
    input  logic                    load_ena,
    input  logic                    clear,
    output logic                    set,
    output logic [idx_w(NPAT)-1:0]  match_idx,
    output logic                    busy
);

    localparam int IDXW = idx_w(NPAT);
    localparam int CNTW = cnt_w(HOLD);
    localparam logic [CNTW-1:0] HOLD_C = CNTW'(HOLD);

    logic [NPAT-1:0][WIDTH-1:0] pat_r;
    logic [NPAT-1:0][WIDTH-1:0] mask_r;
    logic [NPAT-1:0]            ena_r;
    logic [WIDTH-1:0]           s_q;
    logic                       v_q;
    state_t                     state_r;
    logic [CNTW-1:0]            cnt_r;
    logic [CNTW-1:0]            cnt_inc_s;
    logic [IDXW-1:0]            cand_r;
    logic                       hit_any_s;
    logic [IDXW-1:0]            cur_idx_s;
    logic                       load_ok_s;
    logic                       load_cand_s;

    assign load_ok_s   = load_en && (int'(load_idx) < NPAT);
    assign load_cand_s = load_ok_s && (load_idx == cand_r);

    // Saturating increment of the consecutive-match counter.
    always_comb begin
        if (cnt_r == HOLD_C) begin
            cnt_inc_s = cnt_r;
        end else begin
            cnt_inc_s = cnt_r + CNTW'(1);
        end
    end

    // Pattern table; the new entry is seen by the compare from the next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NPAT; i++) begin
                pat_r[i]  <= {WIDTH{1'b0}};
                mask_r[i] <= {WIDTH{1'b1}};
            end
            ena_r <= {NPAT{1'b0}};
        end else if (load_ok_s) begin
            pat_r[load_idx]  <= load_pat;
            mask_r[load_idx] <= load_mask;
            ena_r[load_idx]  <= load_ena;
        end
    end

    // Input stage: sample captured on valid, valid flag tracked every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q <= {WIDTH{1'b0}};
            v_q <= 1'b0;
        end else begin
            if (in_valid) begin
                s_q <= in_vec;
            end
            v_q <= in_valid;
        end
    end

    seg_pattern_cmp_bank #(
        .WIDTH (WIDTH),
        .NPAT  (NPAT)
    ) u_cmp (
        .sample  (s_q),
        .pat     (pat_r),
        .mask    (mask_r),
        .ena     (ena_r),
        .hit_any (hit_any_s),
        .cur_idx (cur_idx_s)
    );

    // Qualification FSM with registered set/match_idx/busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            cnt_r     <= {CNTW{1'b0}};
            cand_r    <= {IDXW{1'b0}};
            set       <= 1'b0;
            match_idx <= {IDXW{1'b0}};
            busy      <= 1'b0;
        end else if (clear) begin
            state_r   <= IDLE;
            cnt_r     <= {CNTW{1'b0}};
            set       <= 1'b0;
            match_idx <= {IDXW{1'b0}};
            busy      <= 1'b0;
        end else if ((state_r == QUAL) && load_cand_s) begin
            // The candidate entry changed underneath us: its history is void.
            state_r <= IDLE;
            cnt_r   <= {CNTW{1'b0}};
            busy    <= 1'b0;
        end else if (v_q) begin
            case (state_r)
                IDLE: begin
                    if (hit_any_s) begin
                        cand_r <= cur_idx_s;
                        if (HOLD == 1) begin
                            state_r   <= SET;
                            cnt_r     <= HOLD_C;
                            set       <= 1'b1;
                            match_idx <= cur_idx_s;
                        end else begin
                            state_r <= QUAL;
                            cnt_r   <= CNTW'(1);
                            busy    <= 1'b1;
                        end
                    end
                end
                QUAL: begin
                    if (hit_any_s && (cur_idx_s == cand_r)) begin
                        cnt_r <= cnt_inc_s;
                        if (cnt_inc_s == HOLD_C) begin
                            state_r   <= SET;
                            set       <= 1'b1;
                            match_idx <= cand_r;
                            busy      <= 1'b0;
                        end
                    end else if (hit_any_s) begin
                        cnt_r  <= CNTW'(1);
                        cand_r <= cur_idx_s;
                    end else begin
                        state_r <= IDLE;
                        cnt_r   <= {CNTW{1'b0}};
                        busy    <= 1'b0;
                    end
                end
                SET: begin
                    set <= 1'b1;
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= {CNTW{1'b0}};
                    set     <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
